// File: rtl/combo_lock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : combo_lock_pkg
//  Description : Shared types and helpers for the parametrised combination
//                lock. Provides the state encoding and the digit-range check.
//  Revision    : 1.0 - initial release
// ============================================================================
package combo_lock_pkg;

    // Visible on the state_o port, so the values are pinned explicitly.
    typedef enum logic [2:0] {
        ENTRY   = 3'd0,
        CLOSED  = 3'd1,
        LOCKOUT = 3'd2,
        OPEN    = 3'd3,
        PROGRAM = 3'd4
    } state_t;

    localparam int DIGIT_MAX = 9;

    // Takes a 32-bit argument so the check works for any DIGIT_W.
    function automatic logic digit_ok(input logic [31:0] d);
        return (d <= 32'(DIGIT_MAX));
    endfunction

endpackage
`default_nettype wire

// File: rtl/lockout_timer.sv
`default_nettype none
// ============================================================================
//  Module      : lockout_timer
//  Description : One-shot down counter for the lockout period. Loading sets
//                the count to LOCKOUT_CYCLES-1. The counter then decrements
//                once per cycle. done is high during the cycle in which the
//                count is zero, so the owner spends exactly LOCKOUT_CYCLES
//                cycles waiting.
//  Ports       : clk, rst  - clock and synchronous active-high reset
//                load      - start a new lockout period
//                done      - final cycle of the period
//  Revision    : 1.0 - initial release
// ============================================================================
module lockout_timer #(
    parameter int LOCKOUT_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    localparam int TW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [TW-1:0] C_LOAD = TW'(LOCKOUT_CYCLES - 1);

    logic [TW-1:0] r_cnt;
    logic          r_active;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (load) begin
            r_cnt    <= C_LOAD;
            r_active <= 1'b1;
        end else if (r_active) begin
            if (r_cnt == '0) begin
                r_active <= 1'b0;
            end else begin
                r_cnt <= r_cnt - TW'(1);
            end
        end
    end

    assign done = r_active && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/combo_lock_n.sv
`default_nettype none
// ============================================================================
//  Module      : combo_lock_n
//  Description : Parametrised combination lock. The lock compares a stream of
//                digit strobes against a programmable code. It gives the
//                OPEN/CLOSED verdict only after all DIGITS digits have been
//                entered. MAX_TRIES consecutive failures start a timed
//                lockout. A new code can be programmed only while the lock
//                is open.
//  Ports       : clk, rst     - clock and synchronous active-high reset
//                digit        - digit value, qualified by digit_valid
//                digit_valid  - entry strobe
//                retry        - CLOSED -> ENTRY
//                relock       - OPEN -> ENTRY, also aborts PROGRAM
//                prog         - OPEN -> PROGRAM
//                state_o      - current state (combo_lock_pkg::state_t)
//                is_open, is_closed, locked_out - state decodes
//                digit_idx    - digits accepted in the current sequence
//                fail_cnt     - consecutive failed attempts
//                digit_err    - pulse for an out-of-range digit
//  Revision    : 1.0 - initial release
// ============================================================================
module combo_lock_n
    import combo_lock_pkg::*;
#(
    parameter int                        DIGITS         = 6,
    parameter int                        DIGIT_W        = 4,
    parameter logic [DIGITS*DIGIT_W-1:0] DEFAULT_CODE   = 24'h474023,
    parameter int                        MAX_TRIES      = 3,
    parameter int                        LOCKOUT_CYCLES = 50_000_000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DIGIT_W-1:0]               digit,
    input  logic                             digit_valid,
    input  logic                             retry,
    input  logic                             relock,
    input  logic                             prog,
    output logic [2:0]                       state_o,
    output logic                             is_open,
    output logic                             is_closed,
    output logic                             locked_out,
    output logic [$clog2(DIGITS+1)-1:0]      digit_idx,
    output logic [$clog2(MAX_TRIES+1)-1:0]   fail_cnt,
    output logic                             digit_err
);

    localparam int IW = $clog2(DIGITS + 1);
    localparam int FW = $clog2(MAX_TRIES + 1);
    localparam int CW = DIGITS * DIGIT_W;

    localparam logic [2:0] S_ENTRY   = 3'(ENTRY);
    localparam logic [2:0] S_CLOSED  = 3'(CLOSED);
    localparam logic [2:0] S_LOCKOUT = 3'(LOCKOUT);
    localparam logic [2:0] S_OPEN    = 3'(OPEN);
    localparam logic [2:0] S_PROGRAM = 3'(PROGRAM);

    localparam logic [IW-1:0] C_LAST_IDX = IW'(DIGITS - 1);
    localparam logic [FW-1:0] C_MAX_FAIL = FW'(MAX_TRIES);

    logic [2:0]         r_state;
    logic [IW-1:0]      r_idx;
    logic               r_mismatch;
    logic [FW-1:0]      r_fail;
    logic               r_err;
    logic [CW-1:0]      r_code;
    logic [CW-1:0]      r_shadow;
    logic               r_is_open;
    logic               r_is_closed;
    logic               r_locked_out;

    logic [2:0]         w_nxt_state;
    logic [IW-1:0]      w_nxt_idx;
    logic               w_nxt_mis;
    logic [FW-1:0]      w_nxt_fail;
    logic               w_err;
    logic               w_load;
    logic               w_code_we;
    logic               w_sh_clr;
    logic               w_sh_we;
    logic               w_done;
    logic               w_dok;
    logic               w_dig_bad;
    logic               w_last;
    logic [FW-1:0]      w_fail_inc;
    logic [DIGIT_W-1:0] w_cur;
    logic [CW-1:0]      w_sh_wr;

    lockout_timer #(
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (w_load),
        .done (w_done)
    );

    // Select the stored digit at the current index. Build the shadow image
    // with the incoming digit placed at the current index.
    always_comb begin
        w_cur   = '0;
        w_sh_wr = r_shadow;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IW'(i)) begin
                w_cur                          = r_code[i*DIGIT_W +: DIGIT_W];
                w_sh_wr[i*DIGIT_W +: DIGIT_W]  = digit;
            end
        end
    end

    assign w_dok      = digit_ok(32'(digit));
    assign w_dig_bad  = (digit != w_cur) || !w_dok;
    assign w_last     = (r_idx == C_LAST_IDX);
    assign w_fail_inc = (r_fail >= C_MAX_FAIL) ? C_MAX_FAIL : r_fail + FW'(1);

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_idx   = r_idx;
        w_nxt_mis   = r_mismatch;
        w_nxt_fail  = r_fail;
        w_err       = 1'b0;
        w_load      = 1'b0;
        w_code_we   = 1'b0;
        w_sh_clr    = 1'b0;
        w_sh_we     = 1'b0;
        case (r_state)
            S_ENTRY: begin
                if (digit_valid) begin
                    w_err = !w_dok;
                    if (w_last) begin
                        // The verdict includes the digit that arrives in this cycle.
                        w_nxt_idx = '0;
                        w_nxt_mis = 1'b0;
                        if (!(r_mismatch || w_dig_bad)) begin
                            w_nxt_state = S_OPEN;
                            w_nxt_fail  = '0;
                        end else begin
                            w_nxt_fail = w_fail_inc;
                            if (w_fail_inc == C_MAX_FAIL) begin
                                w_nxt_state = S_LOCKOUT;
                                w_load      = 1'b1;
                            end else begin
                                w_nxt_state = S_CLOSED;
                            end
                        end
                    end else begin
                        w_nxt_idx = r_idx + IW'(1);
                        w_nxt_mis = r_mismatch || w_dig_bad;
                    end
                end
            end
            S_CLOSED: begin
                if (retry) begin
                    w_nxt_state = S_ENTRY;
                end
            end
            S_LOCKOUT: begin
                if (w_done) begin
                    w_nxt_state = S_CLOSED;
                    w_nxt_fail  = '0;
                end
            end
            S_OPEN: begin
                if (relock) begin
                    w_nxt_state = S_ENTRY;
                end else if (prog) begin
                    w_nxt_state = S_PROGRAM;
                    w_nxt_idx   = '0;
                    w_sh_clr    = 1'b1;
                end
            end
            S_PROGRAM: begin
                if (relock) begin
                    w_nxt_state = S_OPEN;
                    w_nxt_idx   = '0;
                end else if (digit_valid) begin
                    if (!w_dok) begin
                        w_err       = 1'b1;
                        w_nxt_state = S_OPEN;
                        w_nxt_idx   = '0;
                    end else begin
                        w_sh_we = 1'b1;
                        if (w_last) begin
                            w_code_we   = 1'b1;
                            w_nxt_state = S_ENTRY;
                            w_nxt_idx   = '0;
                        end else begin
                            w_nxt_idx = r_idx + IW'(1);
                        end
                    end
                end
            end
            default: begin
                w_nxt_state = S_ENTRY;
                w_nxt_idx   = '0;
                w_nxt_mis   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_ENTRY;
            r_idx        <= '0;
            r_mismatch   <= 1'b0;
            r_fail       <= '0;
            r_err        <= 1'b0;
            r_code       <= DEFAULT_CODE;
            r_shadow     <= '0;
            r_is_open    <= 1'b0;
            r_is_closed  <= 1'b0;
            r_locked_out <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_idx        <= w_nxt_idx;
            r_mismatch   <= w_nxt_mis;
            r_fail       <= w_nxt_fail;
            r_err        <= w_err;
            r_is_open    <= (w_nxt_state == S_OPEN);
            r_is_closed  <= (w_nxt_state == S_CLOSED);
            r_locked_out <= (w_nxt_state == S_LOCKOUT);
            if (w_sh_clr) begin
                r_shadow <= '0;
            end else if (w_sh_we) begin
                r_shadow <= w_sh_wr;
            end
            // The final digit is written straight into the code, so the
            // new code takes effect as a whole in one cycle.
            if (w_code_we) begin
                r_code <= w_sh_wr;
            end
        end
    end

    assign state_o    = r_state;
    assign is_open    = r_is_open;
    assign is_closed  = r_is_closed;
    assign locked_out = r_locked_out;
    assign digit_idx  = r_idx;
    assign fail_cnt   = r_fail;
    assign digit_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_combo_lock_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_combo_lock_n
//  Description : Directed self-checking bench for combo_lock_n with
//                DIGITS=6, MAX_TRIES=3, LOCKOUT_CYCLES=8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_combo_lock_n;

    logic       clk;
    logic       rst;
    logic [3:0] digit;
    logic       digit_valid;
    logic       retry;
    logic       relock;
    logic       prog;
    logic [2:0] state_o;
    logic       is_open;
    logic       is_closed;
    logic       locked_out;
    logic [2:0] digit_idx;
    logic [1:0] fail_cnt;
    logic       digit_err;

    int errors = 0;
    int checks = 0;

    localparam logic [2:0] E_ENTRY   = 3'd0;
    localparam logic [2:0] E_CLOSED  = 3'd1;
    localparam logic [2:0] E_LOCKOUT = 3'd2;
    localparam logic [2:0] E_OPEN    = 3'd3;
    localparam logic [2:0] E_PROGRAM = 3'd4;

    combo_lock_n #(
        .DIGITS         (6),
        .DIGIT_W        (4),
        .DEFAULT_CODE   (24'h474023),
        .MAX_TRIES      (3),
        .LOCKOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .digit       (digit),
        .digit_valid (digit_valid),
        .retry       (retry),
        .relock      (relock),
        .prog        (prog),
        .state_o     (state_o),
        .is_open     (is_open),
        .is_closed   (is_closed),
        .locked_out  (locked_out),
        .digit_idx   (digit_idx),
        .fail_cnt    (fail_cnt),
        .digit_err   (digit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        digit_valid = 1'b0; retry = 1'b0; relock = 1'b0; prog = 1'b0; digit = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic enter_digit(input logic [3:0] d);
        digit = d;
        digit_valid = 1'b1;
        tick();
        digit_valid = 1'b0;
    endtask

    // code holds digit 0 in its least significant nibble
    task automatic enter_code(input logic [23:0] code);
        for (int i = 0; i < 6; i++) enter_digit(code[i*4 +: 4]);
    endtask

    task automatic pulse_retry();
        retry = 1'b1; tick(); retry = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (state_o !== E_ENTRY) begin errors++; $display("FAIL reset_state: got %0d want %0d", state_o, E_ENTRY); end
        checks++; if (digit_idx !== 3'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", digit_idx); end
        checks++; if (fail_cnt !== 2'd0) begin errors++; $display("FAIL reset_fail: got %0d want 0", fail_cnt); end
        checks++; if ({is_open, is_closed, locked_out, digit_err} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {is_open, is_closed, locked_out, digit_err}); end
    endtask

    task automatic test_open();
        do_reset();
        enter_digit(4'd3); enter_digit(4'd2); enter_digit(4'd0);
        checks++; if (digit_idx !== 3'd3) begin errors++; $display("FAIL open_mid_idx: got %0d want 3", digit_idx); end
        enter_digit(4'd4); enter_digit(4'd7); enter_digit(4'd4);
        checks++; if (is_open !== 1'b1) begin errors++; $display("FAIL open_flag: got %0b want 1", is_open); end
        checks++; if (state_o !== E_OPEN) begin errors++; $display("FAIL open_state: got %0d want %0d", state_o, E_OPEN); end
        checks++; if (fail_cnt !== 2'd0) begin errors++; $display("FAIL open_fail: got %0d want 0", fail_cnt); end
        checks++; if (digit_idx !== 3'd0) begin errors++; $display("FAIL open_idx: got %0d want 0", digit_idx); end
    endtask

    task automatic test_closed();
        do_reset();
        enter_digit(4'd3); enter_digit(4'd9);
        checks++; if (is_closed !== 1'b0) begin errors++; $display("FAIL closed_early: got %0b want 0", is_closed); end
        checks++; if (state_o !== E_ENTRY) begin errors++; $display("FAIL closed_early_state: got %0d want %0d", state_o, E_ENTRY); end
        enter_digit(4'd0); enter_digit(4'd4); enter_digit(4'd7); enter_digit(4'd4);
        checks++; if (is_closed !== 1'b1) begin errors++; $display("FAIL closed_flag: got %0b want 1", is_closed); end
        checks++; if (fail_cnt !== 2'd1) begin errors++; $display("FAIL closed_fail: got %0d want 1", fail_cnt); end
        enter_digit(4'd3);
        checks++; if (state_o !== E_CLOSED || digit_idx !== 3'd0) begin errors++; $display("FAIL closed_digit_ignored: got state %0d idx %0d want 1/0", state_o, digit_idx); end
        digit = 4'd3; digit_valid = 1'b1; retry = 1'b1;
        tick();
        digit_valid = 1'b0; retry = 1'b0;
        checks++; if (state_o !== E_ENTRY) begin errors++; $display("FAIL retry_state: got %0d want %0d", state_o, E_ENTRY); end
        checks++; if (digit_idx !== 3'd0) begin errors++; $display("FAIL retry_idx: got %0d want 0", digit_idx); end
    endtask

    task automatic test_lockout();
        do_reset();
        enter_code(24'h111111);
        pulse_retry();
        enter_code(24'h111111);
        checks++; if (fail_cnt !== 2'd2) begin errors++; $display("FAIL lock_fail2: got %0d want 2", fail_cnt); end
        pulse_retry();
        enter_code(24'h111111);
        checks++; if (locked_out !== 1'b1 || state_o !== E_LOCKOUT) begin errors++; $display("FAIL lock_enter: got lo %0b state %0d want 1/2", locked_out, state_o); end
        checks++; if (fail_cnt !== 2'd3) begin errors++; $display("FAIL lock_fail3: got %0d want 3", fail_cnt); end
        // Seven more cycles stay locked, even while strobes are driven.
        for (int i = 1; i < 8; i++) begin
            retry = i[0]; digit_valid = ~i[0]; digit = 4'd3;
            tick();
            checks++; if (locked_out !== 1'b1) begin errors++; $display("FAIL lock_hold_%0d: got %0b want 1", i, locked_out); end
        end
        retry = 1'b0; digit_valid = 1'b0;
        tick();
        checks++; if (locked_out !== 1'b0 || is_closed !== 1'b1) begin errors++; $display("FAIL lock_exit: got lo %0b cl %0b want 0/1", locked_out, is_closed); end
        checks++; if (fail_cnt !== 2'd0) begin errors++; $display("FAIL lock_exit_fail: got %0d want 0", fail_cnt); end
    endtask

    task automatic test_digit_err();
        do_reset();
        enter_digit(4'd12);
        checks++; if (digit_err !== 1'b1) begin errors++; $display("FAIL derr_pulse: got %0b want 1", digit_err); end
        checks++; if (digit_idx !== 3'd1) begin errors++; $display("FAIL derr_idx: got %0d want 1", digit_idx); end
        tick();
        checks++; if (digit_err !== 1'b0) begin errors++; $display("FAIL derr_clear: got %0b want 0", digit_err); end
        enter_digit(4'd2); enter_digit(4'd0); enter_digit(4'd4); enter_digit(4'd7); enter_digit(4'd4);
        checks++; if (is_closed !== 1'b1 || is_open !== 1'b0) begin errors++; $display("FAIL derr_verdict: got cl %0b op %0b want 1/0", is_closed, is_open); end
    endtask

    task automatic test_program();
        do_reset();
        enter_code(24'h474023);
        prog = 1'b1; tick(); prog = 1'b0;
        checks++; if (state_o !== E_PROGRAM) begin errors++; $display("FAIL prog_enter: got %0d want %0d", state_o, E_PROGRAM); end
        enter_code(24'h332211);
        checks++; if (state_o !== E_ENTRY || fail_cnt !== 2'd0) begin errors++; $display("FAIL prog_done: got state %0d fail %0d want 0/0", state_o, fail_cnt); end
        enter_code(24'h474023);
        checks++; if (is_closed !== 1'b1) begin errors++; $display("FAIL prog_old_code: got %0b want 1", is_closed); end
        pulse_retry();
        enter_code(24'h332211);
        checks++; if (is_open !== 1'b1) begin errors++; $display("FAIL prog_new_code: got %0b want 1", is_open); end
    endtask

    task automatic test_prog_abort();
        do_reset();
        enter_code(24'h474023);
        prog = 1'b1; tick(); prog = 1'b0;
        enter_digit(4'd1); enter_digit(4'd1); enter_digit(4'd2);
        checks++; if (digit_idx !== 3'd3) begin errors++; $display("FAIL pabort_idx: got %0d want 3", digit_idx); end
        do_reset();
        checks++; if (state_o !== E_ENTRY) begin errors++; $display("FAIL pabort_rst_state: got %0d want 0", state_o); end
        enter_code(24'h474023);
        checks++; if (is_open !== 1'b1) begin errors++; $display("FAIL pabort_rst_code: got %0b want 1", is_open); end
        prog = 1'b1; tick(); prog = 1'b0;
        enter_digit(4'd5);
        enter_digit(4'd10);
        checks++; if (digit_err !== 1'b1 || state_o !== E_OPEN) begin errors++; $display("FAIL pabort_bad: got err %0b state %0d want 1/3", digit_err, state_o); end
        relock = 1'b1; tick(); relock = 1'b0;
        enter_code(24'h474023);
        checks++; if (is_open !== 1'b1) begin errors++; $display("FAIL pabort_code_kept: got %0b want 1", is_open); end
    endtask

    task automatic test_back_to_back();
        // The lock is open here: relock and prog together must relock.
        relock = 1'b1; prog = 1'b1; tick(); relock = 1'b0; prog = 1'b0;
        checks++; if (state_o !== E_ENTRY) begin errors++; $display("FAIL b2b_relock_wins: got %0d want 0", state_o); end
        enter_code(24'h474023);
        enter_code(24'h474023);
        checks++; if (is_open !== 1'b1 || digit_idx !== 3'd0) begin errors++; $display("FAIL b2b_ignore_open_digits: got op %0b idx %0d want 1/0", is_open, digit_idx); end
    endtask

    initial begin
        rst = 1'b1; digit = '0; digit_valid = 1'b0; retry = 1'b0; relock = 1'b0; prog = 1'b0;
        test_reset();
        test_open();
        test_closed();
        test_lockout();
        test_digit_err();
        test_program();
        test_prog_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/combo_lock_n.md
Name: combo_lock_n

Overview:
- Parametrised successor to the lab3 fixed six-digit combination lock.
- Accepts a stream of decimal digit strobes and compares them against a programmable code register.
- Reports OPEN or CLOSED only after the full code length has been entered, so a mismatch is never revealed early.
- Adds a failed-attempt counter with a timed lockout, and a re-program mode that is reachable only while open.
- Sits between debounced board inputs (switches/keys) and a display/status decoder.

Parameters:
- DIGITS, 6: code length in digits (2..16).
- DIGIT_W, 4: bits per digit. Legal digit values are 0..9; 10..2^DIGIT_W-1 are out-of-range.
- DEFAULT_CODE, 24'h474023: reset code, width DIGITS*DIGIT_W. Digit 0 is in the LSBs. The default is digits 3,2,0,4,7,4.
- MAX_TRIES, 3: consecutive failed attempts that trigger lockout (≥1).
- LOCKOUT_CYCLES, 50_000_000: lockout duration in clk cycles (≥1).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- digit  in  DIGIT_W  digit value, sampled only when digit_valid=1
- digit_valid  in  1  single-cycle entry strobe
- retry  in  1  single-cycle strobe: CLOSED -> ENTRY
- relock  in  1  single-cycle strobe: OPEN -> ENTRY
- prog  in  1  single-cycle strobe: OPEN -> PROGRAM
- state_o  out  3  current state encoding (package enum)
- is_open  out  1  state==OPEN
- is_closed  out  1  state==CLOSED
- locked_out  out  1  state==LOCKOUT
- digit_idx  out  $clog2(DIGITS+1)  digits accepted in the current entry/program sequence
- fail_cnt  out  $clog2(MAX_TRIES+1)  consecutive failures
- digit_err  out  1  one-cycle pulse for an out-of-range digit accepted in ENTRY or PROGRAM

Behaviour:
- General rules:
  - All outputs are registered. A strobe sampled at edge N is reflected in the outputs after edge N.
  - Reset values: state=ENTRY, digit_idx=0, fail_cnt=0, digit_err=0, code=DEFAULT_CODE, mismatch flag=0, timer=0.
  - Reset has priority over every input. Reset mid-sequence discards partial entry and any pending program data.
- ENTRY:
  - On digit_valid, set mismatch |= (digit != code[idx]) | (digit>9), then increment idx.
  - An out-of-range digit also pulses digit_err.
  - On the DIGITS-th digit, evaluate: match -> OPEN with fail_cnt=0.
  - Otherwise increment fail_cnt. If the new value == MAX_TRIES -> LOCKOUT with timer=LOCKOUT_CYCLES-1; else -> CLOSED.
  - idx and mismatch clear on every exit from ENTRY.
  - retry, relock and prog are ignored in ENTRY.
- CLOSED:
  - retry -> ENTRY. digit_valid is ignored.
  - retry and digit_valid in the same cycle: retry wins and the digit is dropped.
- LOCKOUT:
  - Timer decrements each cycle. At timer==0 -> CLOSED with fail_cnt=0.
  - All strobes are ignored. Total residence is exactly LOCKOUT_CYCLES cycles.
- OPEN:
  - relock -> ENTRY.
  - prog -> PROGRAM, clearing the shadow code.
  - relock and prog together: relock wins.
  - digit_valid is ignored.
- PROGRAM:
  - digit_valid with digit<=9 writes shadow[idx] and increments idx.
  - digit>9 pulses digit_err and aborts to OPEN; the live code is unchanged.
  - relock aborts to OPEN with the code unchanged.
  - On the DIGITS-th valid digit, the shadow is copied into the code atomically and the next state is ENTRY (locked). fail_cnt stays 0.
- Counter widths:
  - idx never exceeds DIGITS.
  - fail_cnt saturates at MAX_TRIES and never wraps.
  - The timer is $clog2(LOCKOUT_CYCLES) bits wide, minimum 1.
- Illegal state encoding -> ENTRY on the next clock.

Decomposition:
- Package combo_lock_pkg holds:
  - state_t enum {ENTRY, CLOSED, LOCKOUT, OPEN, PROGRAM}, 3 bits
  - localparam DIGIT_MAX=9
  - function digit_ok(d) returning d<=DIGIT_MAX
- One sub-module, lockout_timer: load, count-down, and a done pulse, parametrised by LOCKOUT_CYCLES.
- The FSM, code register and shadow register live in combo_lock_n.

Test Plan (DIGITS=6, MAX_TRIES=3, LOCKOUT_CYCLES=8):
1. Reset, enter 3,2,0,4,7,4 -> is_open=1 the cycle after the 6th strobe, fail_cnt=0, digit_idx=0.
2. Reset, enter 3,9,0,4,7,4 -> is_closed=1 only after the 6th strobe (is_closed=0 after the 2nd), fail_cnt=1. Then retry + digit_valid in the same cycle -> ENTRY, digit_idx=0.
3. Three wrong sequences (retry between) -> after the 3rd: locked_out=1 for exactly 8 cycles, retry/digit strobes ignored. Then is_closed=1, fail_cnt=0.
4. Digit 12 as the 1st entry -> digit_err pulses for 1 cycle. After 6 digits the result is CLOSED even if the other five digits match.
5. From OPEN: prog, then 1,1,2,2,3,3 -> state ENTRY. Old code 3,2,0,4,7,4 now fails; 1,1,2,2,3,3 opens.
6. In PROGRAM after 3 digits, assert rst -> code reverts to 474023 and state=ENTRY. Separately, in PROGRAM a digit of 10 -> OPEN with the code unchanged.
